hazard_ctrl: RTL and testbench
==============================

// Module: hazard_ctrl
// PURPOSE
//  Pipeline interlock unit for the Minisys-1A 5-stage core; sits beside the forwarding unit.
//  - Inserts bubbles where forwarding cannot cover the hazard: load-use, and branch/jr operands resolved in ID.
//  - Owns the busy counter of the multi-cycle HI/LO divider and blocks HI/LO access until it finishes.
//  - Drives the PC, IF/ID and ID/EX write/flush controls.
// PARAMETERS
//  DIV_CYCLES  32                         cycles the divider needs from EX_DivStart to result ready (>=1)
//  CNT_W       $clog2(DIV_CYCLES+1)       width of the divide busy counter
// PORTS
//  clock           in   1   core clock, rising edge
//  reset           in   1   asynchronous, active-low reset
//  ID_rs           in   5   rs field of instruction in ID
//  ID_rt           in   5   rt field of instruction in ID
//  ID_UseRs        in   1   ID instruction reads rs
//  ID_UseRt        in   1   ID instruction reads rt
//  ID_Branch       in   1   ID instruction is beq/bne/bgez../jr/jalr (operands consumed in ID)
//  ID_HiLo         in   1   ID instruction is mfhi/mflo/mthi/mtlo/mult/div
//  ID_EX_MemRead   in   1   instruction in EX is a load
//  ID_EX_RegWrite  in   1   instruction in EX writes a GPR
//  ID_EX_waddr     in   5   destination GPR of EX instruction
//  EX_MEM_MemRead  in   1   instruction in MEM is a load
//  EX_MEM_waddr    in   5   destination GPR of MEM instruction
//  EX_DivStart     in   1   div/divu in EX this cycle (one-cycle pulse)
//  Exc_Flush       in   1   exception/eret redirect this cycle
//  PCWrite         out  1   PC may update
//  IF_ID_Write     out  1   IF/ID register may load
//  IF_ID_Flush     out  1   IF/ID register loads a nop
//  ID_EX_Flush     out  1   ID/EX register loads a bubble
//  DivBusy         out  1   divider running (count != 0)
//  DivDone         out  1   last divide cycle (count == 1); HI/LO written at this edge
// BEHAVIOUR
//  Hazard match terms (waddr==0 never matches):
//   mEX  = (ID_UseRs && ID_rs==ID_EX_waddr) || (ID_UseRt && ID_rt==ID_EX_waddr)
//   mMEM = the same test against EX_MEM_waddr
//  Stall conditions:
//   load_use = ID_EX_MemRead && mEX
//   br_haz   = ID_Branch && ((ID_EX_MemRead && mEX) || (EX_MEM_MemRead && mMEM))
//   hilo_haz = ID_HiLo && DivBusy
//   stall    = load_use || br_haz || hilo_haz
//  Branch on a non-load EX/MEM result: no stall; the forwarding unit's ID-stage paths cover it.
//  A branch behind a load in EX stalls 2 cycles: the load moves to MEM and br_haz stays true one more cycle.
//  Output priority: Exc_Flush > stall > run.
//   Exc_Flush:  PCWrite=1, IF_ID_Write=1, IF_ID_Flush=1, ID_EX_Flush=1.
//   stall:      PCWrite=0, IF_ID_Write=0, IF_ID_Flush=0, ID_EX_Flush=1.
//   run:        PCWrite=1, IF_ID_Write=1, IF_ID_Flush=0, ID_EX_Flush=0.
//  Stall outputs are combinational (same cycle as the condition). Counter state is the only sequential state.
//  Divide counter cnt[CNT_W-1:0], updated on posedge clock. Priority:
//   1. Exc_Flush: cnt <= 0 (abort).
//   2. Else EX_DivStart && cnt==0: cnt <= DIV_CYCLES.
//   3. Else cnt!=0: cnt <= cnt-1.
//  EX_DivStart while cnt!=0 cannot occur, since hilo_haz holds any div in ID. If it does, it is ignored;
//  the bench flags it as a protocol error.
//  DivBusy = (cnt!=0); DivDone = (cnt==1), giving exactly one pulse per completed divide.
//  An aborted divide produces no DivDone.
//  Reset (reset==0, async): cnt=0, so DivBusy=0 and DivDone=0.
//   With other inputs idle: PCWrite=1, IF_ID_Write=1, IF_ID_Flush=0, ID_EX_Flush=0.
//  Reset mid-divide discards the divide immediately, without waiting for the clock.
// TESTING
//  T1 EX: lw $3; ID: add rs=3 UseRs=1 -> 1 cycle of PCWrite=0, IF_ID_Write=0, ID_EX_Flush=1; next cycle run.
//  T2 EX: lw $0; ID: rs=0 -> no stall. EX: addu $5; ID: beq rs=5 -> no stall.
//  T3 EX: lw $5; ID: beq rs=5 -> stall 2 cycles (EX then MEM match), branch proceeds on cycle 3.
//  T4 DIV_CYCLES=32, EX_DivStart at cycle 0 -> DivBusy cycles 1..32, DivDone at cycle 32;
//     mflo in ID from cycle 1 stalls through cycle 32 and proceeds at cycle 33.
//  T5 Exc_Flush at cycle 10 of a divide -> DivBusy=0 next cycle, no DivDone;
//     that cycle IF_ID_Flush=1, ID_EX_Flush=1, PCWrite=1 even with load_use true.
//  T6 reset asserted mid-divide (cnt=17) between edges -> DivBusy and DivDone 0 at once; run after release.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Pipeline interlock for the 5-stage core: load-use and ID-branch bubbles,
// HI/LO divider busy tracking, and PC / IF/ID / ID/EX write-flush control.
module hazard_ctrl #(
  parameter int DIV_CYCLES = 32,
  parameter int CNT_W      = $clog2(DIV_CYCLES + 1)
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [4:0] ID_rs,
  input  logic [4:0] ID_rt,
  input  logic       ID_UseRs,
  input  logic       ID_UseRt,
  input  logic       ID_Branch,
  input  logic       ID_HiLo,
  input  logic       ID_EX_MemRead,
  input  logic       ID_EX_RegWrite,
  input  logic [4:0] ID_EX_waddr,
  input  logic       EX_MEM_MemRead,
  input  logic [4:0] EX_MEM_waddr,
  input  logic       EX_DivStart,
  input  logic       Exc_Flush,
  output logic       PCWrite,
  output logic       IF_ID_Write,
  output logic       IF_ID_Flush,
  output logic       ID_EX_Flush,
  output logic       DivBusy,
  output logic       DivDone
);

  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [CNT_W-1:0] cnt;
  logic             m_ex;
  logic             m_mem;
  logic             load_use;
  logic             br_haz;
  logic             hilo_haz;
  logic             stall;

  // Non-load EX results are always forwardable, so RegWrite plays no part in interlocking.
  logic unused_regwrite;
  assign unused_regwrite = ID_EX_RegWrite;

  // $zero is never a real dependency.
  assign m_ex  = (ID_EX_waddr != 5'd0) &&
                 ((ID_UseRs && (ID_rs == ID_EX_waddr)) ||
                  (ID_UseRt && (ID_rt == ID_EX_waddr)));
  assign m_mem = (EX_MEM_waddr != 5'd0) &&
                 ((ID_UseRs && (ID_rs == EX_MEM_waddr)) ||
                  (ID_UseRt && (ID_rt == EX_MEM_waddr)));

  assign load_use = ID_EX_MemRead && m_ex;
  assign br_haz   = ID_Branch && ((ID_EX_MemRead && m_ex) || (EX_MEM_MemRead && m_mem));
  assign hilo_haz = ID_HiLo && DivBusy;
  assign stall    = load_use || br_haz || hilo_haz;

  assign DivBusy = (cnt != '0);
  assign DivDone = (cnt == CNT_ONE);

  always_comb begin
    PCWrite     = 1'b1;
    IF_ID_Write = 1'b1;
    IF_ID_Flush = 1'b0;
    ID_EX_Flush = 1'b0;
    if (Exc_Flush) begin
      IF_ID_Flush = 1'b1;
      ID_EX_Flush = 1'b1;
    end else if (stall) begin
      PCWrite     = 1'b0;
      IF_ID_Write = 1'b0;
      ID_EX_Flush = 1'b1;
    end
  end

  // A start while busy is ignored; the ID-stage HI/LO interlock keeps it from happening.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (Exc_Flush) begin
      cnt <= '0;
    end else if (EX_DivStart && (cnt == '0)) begin
      cnt <= DIV_LOAD;
    end else if (cnt != '0) begin
      cnt <= cnt - CNT_ONE;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: combinational vector table plus
// directed multi-cycle sequences for branch-after-load, divide, abort and reset.
module tb_hazard_ctrl;

  logic       clock = 1'b0;
  logic       reset;
  logic [4:0] ID_rs, ID_rt, ID_EX_waddr, EX_MEM_waddr;
  logic       ID_UseRs, ID_UseRt, ID_Branch, ID_HiLo;
  logic       ID_EX_MemRead, ID_EX_RegWrite, EX_MEM_MemRead;
  logic       EX_DivStart, Exc_Flush;
  logic       PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, DivBusy, DivDone;

  int checks   = 0;
  int failures = 0;

  localparam logic [3:0] RUN   = 4'b1100;
  localparam logic [3:0] STALL = 4'b0001;
  localparam logic [3:0] FLUSH = 4'b1111;

  hazard_ctrl #(.DIV_CYCLES(32)) dut (
    .clock(clock), .reset(reset),
    .ID_rs(ID_rs), .ID_rt(ID_rt), .ID_UseRs(ID_UseRs), .ID_UseRt(ID_UseRt),
    .ID_Branch(ID_Branch), .ID_HiLo(ID_HiLo),
    .ID_EX_MemRead(ID_EX_MemRead), .ID_EX_RegWrite(ID_EX_RegWrite),
    .ID_EX_waddr(ID_EX_waddr), .EX_MEM_MemRead(EX_MEM_MemRead),
    .EX_MEM_waddr(EX_MEM_waddr), .EX_DivStart(EX_DivStart), .Exc_Flush(Exc_Flush),
    .PCWrite(PCWrite), .IF_ID_Write(IF_ID_Write), .IF_ID_Flush(IF_ID_Flush),
    .ID_EX_Flush(ID_EX_Flush), .DivBusy(DivBusy), .DivDone(DivDone)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [4:0] rs, rt;
    logic       use_rs, use_rt, br, hilo;
    logic       ex_mr, ex_rw;
    logic [4:0] ex_wa;
    logic       mem_mr;
    logic [4:0] mem_wa;
    logic       exc;
    logic [3:0] exp;
  } vec_t;

  vec_t vecs[14];

  function automatic vec_t mk(logic [4:0] rs, logic [4:0] rt, logic use_rs, logic use_rt,
                              logic br, logic hilo, logic ex_mr, logic ex_rw, logic [4:0] ex_wa,
                              logic mem_mr, logic [4:0] mem_wa, logic exc, logic [3:0] exp);
    vec_t v;
    v.rs = rs; v.rt = rt; v.use_rs = use_rs; v.use_rt = use_rt; v.br = br; v.hilo = hilo;
    v.ex_mr = ex_mr; v.ex_rw = ex_rw; v.ex_wa = ex_wa; v.mem_mr = mem_mr; v.mem_wa = mem_wa;
    v.exc = exc; v.exp = exp;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_ctl(input string name, input logic [3:0] exp);
    chk(name, {28'd0, PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Flush}, {28'd0, exp});
  endtask

  task automatic idle();
    ID_rs = 0; ID_rt = 0; ID_UseRs = 0; ID_UseRt = 0; ID_Branch = 0; ID_HiLo = 0;
    ID_EX_MemRead = 0; ID_EX_RegWrite = 0; ID_EX_waddr = 0;
    EX_MEM_MemRead = 0; EX_MEM_waddr = 0; EX_DivStart = 0; Exc_Flush = 0;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  always @(negedge clock) begin
    if (reset && EX_DivStart && DivBusy) begin
      failures++;
      $display("FAIL div_protocol: EX_DivStart while DivBusy at %0t", $time);
    end
  end

  initial begin
    logic saw_done;
    idle();
    reset = 1'b0;
    #1;
    chk("rst_busy", DivBusy, 0);
    chk("rst_done", DivDone, 0);
    chk_ctl("rst_ctl", RUN);
    #1 reset = 1'b1;

    //            rs rt urs urt br hl exmr exrw exwa memmr memwa exc exp
    vecs[0]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, RUN);
    vecs[1]  = mk(3, 0, 1, 0, 0, 0, 1, 1, 3, 0, 0, 0, STALL);
    vecs[2]  = mk(3, 0, 0, 0, 0, 0, 1, 1, 3, 0, 0, 0, RUN);
    vecs[3]  = mk(1, 3, 1, 1, 0, 0, 1, 1, 3, 0, 0, 0, STALL);
    vecs[4]  = mk(0, 0, 1, 0, 0, 0, 1, 1, 0, 0, 0, 0, RUN);
    vecs[5]  = mk(5, 0, 1, 0, 1, 0, 0, 1, 5, 0, 0, 0, RUN);
    vecs[6]  = mk(5, 0, 1, 0, 1, 0, 0, 0, 0, 1, 5, 0, STALL);
    vecs[7]  = mk(5, 0, 1, 0, 0, 0, 0, 0, 0, 1, 5, 0, RUN);
    vecs[8]  = mk(0, 0, 1, 0, 1, 0, 0, 0, 0, 1, 0, 0, RUN);
    vecs[9]  = mk(3, 0, 1, 0, 0, 0, 1, 1, 3, 0, 0, 1, FLUSH);
    vecs[10] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, FLUSH);
    vecs[11] = mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, RUN);
    vecs[12] = mk(2, 7, 1, 1, 1, 0, 1, 1, 7, 0, 0, 0, STALL);
    vecs[13] = mk(4, 6, 1, 1, 1, 0, 1, 1, 9, 1, 8, 0, RUN);

    for (int i = 0; i < 14; i++) begin
      ID_rs = vecs[i].rs; ID_rt = vecs[i].rt;
      ID_UseRs = vecs[i].use_rs; ID_UseRt = vecs[i].use_rt;
      ID_Branch = vecs[i].br; ID_HiLo = vecs[i].hilo;
      ID_EX_MemRead = vecs[i].ex_mr; ID_EX_RegWrite = vecs[i].ex_rw; ID_EX_waddr = vecs[i].ex_wa;
      EX_MEM_MemRead = vecs[i].mem_mr; EX_MEM_waddr = vecs[i].mem_wa;
      Exc_Flush = vecs[i].exc;
      #1;
      chk($sformatf("vec%0d", i), {28'd0, PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Flush},
          {28'd0, vecs[i].exp});
    end
    idle();
    step();

    // Load-use: one stall cycle, then the load has moved on.
    ID_EX_MemRead = 1; ID_EX_RegWrite = 1; ID_EX_waddr = 3; ID_rs = 3; ID_UseRs = 1;
    #1 chk_ctl("t1_stall", STALL);
    step();
    ID_EX_MemRead = 0; ID_EX_RegWrite = 0; ID_EX_waddr = 0;
    EX_MEM_MemRead = 1; EX_MEM_waddr = 3;
    #1 chk_ctl("t1_run", RUN);
    idle();

    // Branch behind a load: stall while the load is in EX and again in MEM.
    step();
    ID_EX_MemRead = 1; ID_EX_RegWrite = 1; ID_EX_waddr = 5; ID_rs = 5; ID_UseRs = 1; ID_Branch = 1;
    #1 chk_ctl("t3_c1", STALL);
    step();
    ID_EX_MemRead = 0; ID_EX_RegWrite = 0; ID_EX_waddr = 0; EX_MEM_MemRead = 1; EX_MEM_waddr = 5;
    #1 chk_ctl("t3_c2", STALL);
    step();
    EX_MEM_MemRead = 0; EX_MEM_waddr = 0;
    #1 chk_ctl("t3_c3", RUN);
    idle();

    // Full divide with mflo waiting in ID.
    step();
    EX_DivStart = 1;
    #1 chk("t4_c0_busy", DivBusy, 0);
    for (int c = 1; c <= 34; c++) begin
      step();
      EX_DivStart = 0;
      ID_HiLo = 1;
      #1;
      chk($sformatf("t4_busy_c%0d", c), DivBusy, (c <= 32) ? 1 : 0);
      chk($sformatf("t4_done_c%0d", c), DivDone, (c == 32) ? 1 : 0);
      chk_ctl($sformatf("t4_ctl_c%0d", c), (c <= 32) ? STALL : RUN);
    end
    idle();

    // Exception at cycle 10 of a divide aborts it.
    step();
    EX_DivStart = 1;
    for (int c = 1; c <= 10; c++) begin
      step();
      EX_DivStart = 0;
    end
    Exc_Flush = 1; ID_EX_MemRead = 1; ID_EX_RegWrite = 1; ID_EX_waddr = 4; ID_rs = 4; ID_UseRs = 1;
    #1;
    chk_ctl("t5_flush_ctl", FLUSH);
    chk("t5_busy_before", DivBusy, 1);
    step();
    idle();
    #1;
    chk("t5_busy_after", DivBusy, 0);
    chk("t5_done_after", DivDone, 0);
    saw_done = 0;
    for (int c = 0; c < 40; c++) begin
      step();
      if (DivDone) saw_done = 1;
    end
    chk("t5_no_done", saw_done, 0);

    // Asynchronous reset mid-divide at cnt=17.
    step();
    EX_DivStart = 1;
    for (int c = 1; c <= 16; c++) begin
      step();
      EX_DivStart = 0;
    end
    #2;
    chk("t6_busy_pre", DivBusy, 1);
    reset = 1'b0;
    #1;
    chk("t6_busy_rst", DivBusy, 0);
    chk("t6_done_rst", DivDone, 0);
    #1 reset = 1'b1;
    step();
    #1;
    chk("t6_busy_post", DivBusy, 0);
    chk_ctl("t6_ctl_post", RUN);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
